// File: rtl/instr_encoder_if.sv
// Handshake bundle between the command source and instr_encoder.
// master = command source / memory side, slave = encoder.
// Carries the run control, the instruction beat channel and the memory write channel.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  // run control
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              err;
  // instruction beat channel
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [25:0]       in_imm;
  // instruction-memory write channel
  logic              wr_en;
  logic              mem_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output start, base_addr, len,
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm,
    output mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, base_addr, len,
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm,
    input  mem_ready,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Symbolic MIPS instruction -> 32-bit word encoder that loads words into instruction memory.
// Latency: beat accepted at edge N appears on wr_en/wr_addr/wr_data from cycle N+1.
// Backpressure: one-entry output register; in_ready drops while a write is stalled by mem_ready.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;      // beats accepted so far in this run
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_err;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_fire;
  logic              w_last;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_sh;
  logic [15:0]       w_imm16;

  assign w_rs    = bus.in_rs;
  assign w_rt    = bus.in_rt;
  assign w_rd    = bus.in_rd;
  assign w_sh    = bus.in_shamt;
  assign w_imm16 = bus.in_imm[15:0];

  // A new beat may enter in the same cycle the held write drains.
  assign w_in_ready = (r_state == S_RUN) && (r_idx < r_len) && (!r_wr_en || bus.mem_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_fire     = r_wr_en && bus.mem_ready;
  // The output register holds at most one write, so the run ends when the
  // write draining with every beat already accepted completes.
  assign w_last     = w_fire && (r_idx == r_len);

  // Assemble the instruction word; only the fields each format uses reach the word.
  always_comb begin
    w_word    = 32'h0000_0000;
    w_illegal = 1'b0;
    case (bus.in_mnem)
      5'd0:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100000};
      5'd1:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100001};
      5'd2:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100010};
      5'd3:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100011};
      5'd4:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100100};
      5'd5:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100101};
      5'd6:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100110};
      5'd7:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b100111};
      5'd8:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b101010};
      5'd9:  w_word = {6'b000000, w_rs, w_rt, w_rd, 5'd0, 6'b101011};
      5'd10: w_word = {6'b000000, 5'd0, w_rt, w_rd, w_sh, 6'b000000};
      5'd11: w_word = {6'b000000, 5'd0, w_rt, w_rd, w_sh, 6'b000010};
      5'd12: w_word = {6'b000000, 5'd0, w_rt, w_rd, w_sh, 6'b000011};
      5'd13: w_word = {6'b000000, w_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      5'd14: w_word = {6'b000000, w_rs, 5'd0, w_rd, 5'd0, 6'b001001};
      5'd15: w_word = {6'b100011, w_rs, w_rt, w_imm16};
      5'd16: w_word = {6'b101011, w_rs, w_rt, w_imm16};
      5'd17: w_word = {6'b001111, 5'd0, w_rt, w_imm16};
      5'd18: w_word = {6'b001000, w_rs, w_rt, w_imm16};
      5'd19: w_word = {6'b001001, w_rs, w_rt, w_imm16};
      5'd20: w_word = {6'b001100, w_rs, w_rt, w_imm16};
      5'd21: w_word = {6'b001010, w_rs, w_rt, w_imm16};
      5'd22: w_word = {6'b001011, w_rs, w_rt, w_imm16};
      5'd23: w_word = {6'b000100, w_rs, w_rt, w_imm16};
      5'd24: w_word = {6'b000101, w_rs, w_rt, w_imm16};
      5'd25: w_word = {6'b000110, w_rs, 5'd0, w_imm16};
      5'd26: w_word = {6'b000111, w_rs, 5'd0, w_imm16};
      5'd27: w_word = {6'b000001, w_rs, 5'd0, w_imm16};
      5'd28: w_word = {6'b000010, bus.in_imm};
      5'd29: w_word = {6'b000011, bus.in_imm};
      default: begin
        w_word    = 32'h0000_0000;
        w_illegal = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: empty runs go straight to DONE; DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = (bus.len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run parameters, beat counter, output write register and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_base <= bus.base_addr;
        r_len  <= bus.len;
        r_idx  <= '0;
        r_err  <= 1'b0;
      end
      if (w_accept) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_base + r_idx[ADDR_W-1:0];
        r_wr_data <= w_word;
        r_idx     <= r_idx + IDX_ONE;
        if (w_illegal) r_err <= 1'b1;
      end else if (w_fire) begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a transaction-level model predicts every
// cycle's outputs, and each scenario's written words are also pinned to
// hand-assembled constants.
module tb_instr_encoder;

  localparam int AW = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS tables indexed by mnemonic offset within each format group.
  int RFUN [10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int SFUN [3]  = '{0, 2, 3};
  int IOP  [13] = '{35, 43, 15, 8, 9, 12, 10, 11, 4, 5, 6, 7, 1};

  // Returns {illegal, word}.
  function automatic logic [32:0] enc(input logic [4:0] m, rs, rt, rd, sh,
                                      input logic [25:0] im);
    int op, fn;
    bit ur, ut, ud, us, i16, i26;
    logic [31:0] w;
    op = 0; fn = 0; ur = 0; ut = 0; ud = 0; us = 0; i16 = 0; i26 = 0;
    if (m <= 9)       begin ur = 1; ut = 1; ud = 1; fn = RFUN[m]; end
    else if (m <= 12) begin ut = 1; ud = 1; us = 1; fn = SFUN[m - 10]; end
    else if (m == 13) begin ur = 1; fn = 8; end
    else if (m == 14) begin ur = 1; ud = 1; fn = 9; end
    else if (m <= 27) begin op = IOP[m - 15]; ur = (m != 17); ut = (m <= 24); i16 = 1; end
    else if (m <= 29) begin op = int'(m) - 26; i26 = 1; end
    else return {1'b1, 32'h0};
    w = 32'(op) << 26;
    if (ur)  w = w | (32'(rs) << 21);
    if (ut)  w = w | (32'(rt) << 16);
    if (ud)  w = w | (32'(rd) << 11);
    if (us)  w = w | (32'(sh) << 6);
    if (i16) w = w | 32'(im[15:0]);
    if (i26) w = w | 32'(im);
    w = w | 32'(fn);
    return {1'b0, w};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic [39:0] m_q[$];      // pending expected writes {addr, data}
  logic [39:0] wr_log[$];   // writes the DUT actually completed
  logic [39:0] exp_log[$];
  bit          m_run, m_done, m_err;
  int          m_len, m_acc, m_wrote;
  logic [7:0]  m_base;

  initial begin
    m_run = 0; m_done = 0; m_err = 0; m_len = 0; m_acc = 0; m_wrote = 0; m_base = '0;
  end

  always @(negedge clk) begin : cmp
    bit exp_wr, exp_rdy, was_idle, nd;
    logic [32:0] e;
    exp_wr   = (m_q.size() != 0);
    exp_rdy  = m_run && (m_acc < m_len) && (!exp_wr || bus.mem_ready);
    was_idle = !m_run && !m_done;
    chk("wr_en",    bus.wr_en,    exp_wr);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("busy",     bus.busy,     m_run);
    chk("done",     bus.done,     m_done);
    chk("err",      bus.err,      m_err);
    if (exp_wr) begin
      chk("wr_addr", bus.wr_addr, m_q[0][39:32]);
      chk("wr_data", bus.wr_data, m_q[0][31:0]);
    end
    if (bus.wr_en && bus.mem_ready) wr_log.push_back({bus.wr_addr, bus.wr_data});
    if (reset) begin
      m_q.delete();
      m_run = 0; m_done = 0; m_err = 0; m_acc = 0; m_wrote = 0; m_len = 0;
    end else begin
      nd = 0;
      if (exp_wr && bus.mem_ready) begin
        void'(m_q.pop_front());
        m_wrote++;
        if (m_wrote == m_len && m_acc == m_len) begin m_run = 0; nd = 1; end
      end
      if (bus.in_valid && exp_rdy) begin
        e = enc(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_imm);
        m_q.push_back({m_base + m_acc[7:0], e[31:0]});
        m_acc++;
        if (e[32]) m_err = 1;
      end
      if (was_idle && bus.start) begin
        m_err = 0;
        m_base = bus.base_addr;
        m_len = int'(bus.len);
        m_acc = 0;
        m_wrote = 0;
        if (bus.len == '0) nd = 1;
        else m_run = 1;
      end
      m_done = nd;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    bus.start = 1'b1; bus.base_addr = b; bus.len = l;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic set_beat(input logic [4:0] m, rs, rt, rd, sh, input logic [25:0] im);
    bus.in_valid = 1'b1;
    bus.in_mnem = m; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = im;
  endtask

  // Presents a beat and returns once it has been accepted (bounded wait).
  task automatic send(input logic [4:0] m, rs, rt, rd, sh, input logic [25:0] im,
                      output int waits);
    set_beat(m, rs, rt, rd, sh, im);
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    chk("beat_accepted", bus.in_ready, 1'b1);
    cyc();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1'b1);
    cyc();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, wr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_log[i][39:32], exp_log[i][39:32]);
      chk($sformatf("%s_data%0d", tag, i), wr_log[i][31:0],  exp_log[i][31:0]);
    end
    wr_log.delete();
    exp_log.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int w;
    total = 0; bad = 0;
    reset = 1'b1;
    bus.start = 0; bus.base_addr = '0; bus.len = '0; bus.mem_ready = 1'b1;
    bus.in_valid = 0; bus.in_mnem = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_shamt = '0; bus.in_imm = '0;
    cyc(); cyc();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en",    bus.wr_en,    0);
    chk("rst_wr_addr",  bus.wr_addr,  0);
    chk("rst_wr_data",  bus.wr_data,  0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    chk("rst_err",      bus.err,      0);
    reset = 1'b0;
    cyc();
    wr_log.delete();

    // single add
    do_start(8'h10, 9'd1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, w);
    wait_done();
    exp_log.push_back({8'h10, 32'h0022_1820});
    check_log("single_add");

    // back-to-back, one per cycle
    do_start(8'h20, 9'd3);
    send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 26'h5, w);  chk("b2b_wait0", w, 0);
    send(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 26'h4, w); chk("b2b_wait1", w, 0);
    send(5'd10, 5'd0, 5'd3, 5'd2, 5'd4, 26'h0, w);  chk("b2b_wait2", w, 0);
    wait_done();
    exp_log.push_back({8'h20, 32'h2008_0005});
    exp_log.push_back({8'h21, 32'h8FA8_0004});
    exp_log.push_back({8'h22, 32'h0003_1100});
    check_log("b2b");

    // field masking: junk in unused fields must not leak
    do_start(8'h30, 9'd3);
    send(5'd27, 5'd5, 5'd7, 5'd9, 5'd3, 26'h3FF_FFFE, w);
    send(5'd14, 5'd25, 5'd4, 5'd31, 5'd2, 26'h3FF, w);
    send(5'd28, 5'd1, 5'd2, 5'd3, 5'd4, 26'h010_0000, w);
    wait_done();
    exp_log.push_back({8'h30, 32'h04A0_FFFE});
    exp_log.push_back({8'h31, 32'h0320_F809});
    exp_log.push_back({8'h32, 32'h0810_0000});
    check_log("mask");

    // memory stall on the 2nd write; stray start during RUN ignored
    do_start(8'h40, 9'd3);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, w);
    send(5'd5, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, w);
    bus.mem_ready = 1'b0;
    set_beat(5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 26'd0);
    bus.start = 1'b1; bus.len = 9'd0;
    cyc();
    bus.start = 1'b0;
    cyc(); cyc();
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_addr",     bus.wr_addr,  8'h41);
    chk("stall_data",     bus.wr_data,  32'h0085_3025);
    bus.mem_ready = 1'b1;
    send(5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 26'd0, w);
    wait_done();
    exp_log.push_back({8'h40, 32'h0022_1820});
    exp_log.push_back({8'h41, 32'h0085_3025});
    exp_log.push_back({8'h42, 32'h00E8_4826});
    check_log("stall");

    // illegal mnemonic writes a nop and sets sticky err
    do_start(8'h50, 9'd2);
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 26'h3FF_FFFF, w);
    send(5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 26'd0, w);
    wait_done();
    chk("err_sticky", bus.err, 1);
    exp_log.push_back({8'h50, 32'h0000_0000});
    exp_log.push_back({8'h51, 32'h0043_2021});
    check_log("illegal");

    // len 0: done next cycle, err cleared, nothing written
    do_start(8'h00, 9'd0);
    chk("len0_done", bus.done, 1);
    chk("len0_err",  bus.err,  0);
    wait_done();
    cyc();
    check_log("len0");

    // address wrap
    do_start(8'hFF, 9'd2);
    send(5'd20, 5'd3, 5'd4, 5'd0, 5'd0, 26'h00FF, w);
    send(5'd17, 5'd9, 5'd10, 5'd0, 5'd0, 26'h1234, w);
    wait_done();
    exp_log.push_back({8'hFF, 32'h3064_00FF});
    exp_log.push_back({8'h00, 32'h3C0A_1234});
    check_log("wrap");

    // reset while a write is stalled
    bus.mem_ready = 1'b0;
    do_start(8'h60, 9'd2);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, w);
    cyc();
    chk("pre_rst_wr_en", bus.wr_en, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_wr_en",    bus.wr_en,    0);
    chk("mid_rst_busy",     bus.busy,     0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    cyc();
    wr_log.delete();
    do_start(8'h70, 9'd1);
    send(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, w);
    wait_done();
    exp_log.push_back({8'h70, 32'h0022_1822});
    check_log("after_rst");

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader: the inverse of the pipeline's opcode/funct control decode. It accepts one symbolic instruction per handshake (mnemonic code plus register, shamt and immediate fields), assembles the 32-bit MIPS word and writes it into instruction memory at consecutive word addresses. It sits between the test/boot command source and the instruction-memory write port, and loads string-search programs before the pipeline is released from reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load run (honoured only in IDLE)
- base_addr  in  ADDR_W  first word address of the run, captured at start
- len  in  ADDR_W+1  number of instructions in the run, captured at start
- in_valid  in  1  instruction beat valid
- in_ready  out  1  encoder accepts beat this cycle
- in_mnem  in  5  mnemonic code (see Operation)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  26  [15:0] I-type immediate/offset; [25:0] J-type target
- wr_en  out  1  instruction-memory write valid
- mem_ready  in  1  memory accepts write this cycle
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  encoded instruction
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky illegal-mnemonic flag, cleared by next accepted start

## Operation
- Mnemonic codes: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 jr, 14 jalr, 15 lw, 16 sw, 17 lui, 18 addi, 19 addiu, 20 andi, 21 slti, 22 sltiu, 23 beq, 24 bne, 25 blez, 26 bgtz, 27 bltz, 28 j, 29 jal; 30-31 illegal.
- R-type ALU (0-9): {000000, rs, rt, rd, 00000, funct}; functs 100000/100001/100010/100011/100100/100101/100110/100111/101010/101011.
- Shifts (10-12): {000000, 00000, rt, rd, shamt, 000000/000010/000011}.
- jr: {000000, rs, 00000, 00000, 00000, 001000}; jalr: {000000, rs, 00000, rd, 00000, 001001}.
- I-type (15-24): {op, rs, rt, imm[15:0]}; ops lw 100011, sw 101011, lui 001111 (rs forced 0), addi 001000, addiu 001001, andi 001100, slti 001010, sltiu 001011, beq 000100, bne 000101.
- blez 000110, bgtz 000111, bltz 000001: rt forced 0.
- j 000010, jal 000011: {op, imm[25:0]}.
- Unused field inputs ignored (masked, never leaked into the word).
- Illegal code: writes 0x00000000 (nop) at that address, sets err; run continues.
- FSM: IDLE -> RUN on start with len != 0; IDLE -> DONE on start with len == 0; RUN -> DONE when the len-th write completes (wr_en && mem_ready); DONE -> IDLE unconditionally after one cycle.
- Index counter (ADDR_W+1 bits) counts accepted beats; wr_addr = base_addr + index, modulo 2^ADDR_W (wraps silently).

## Timing
- Reset values: in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0, state IDLE.
- in_ready = RUN && accepted < len && (!wr_en || mem_ready).
- Beat accepted at edge N (in_valid && in_ready) -> wr_en, wr_addr, wr_data registered, valid from cycle N+1.
- wr_en held with stable addr/data until mem_ready; write completes on wr_en && mem_ready.
- Throughput 1 instr/cycle with mem_ready tied high; new beat may be accepted in the same cycle the previous write completes.
- done pulses in the cycle after final write completes (DONE state); busy low in that cycle.
- start in RUN/DONE ignored; in_valid in IDLE/DONE ignored (in_ready 0).
- reset mid-run: pending write dropped (wr_en 0 next cycle), counter cleared, IDLE, err cleared.

## Test plan
- start base 0x10 len 1; add rs1 rt2 rd3 -> one write, addr 0x10, data 0x00221820; done one cycle later.
- Back-to-back addi rt8 imm5, lw rs29 rt8 imm4, sll rt3 rd2 shamt4, mem_ready=1 -> 0x20080005, 0x8FA80004, 0x00031100 at consecutive addresses, one per cycle.
- bltz rs5 rt7 imm 0xFFFE; jalr rs25 rd31; j imm 0x0100000 -> 0x04A0FFFE (rt masked), 0x0320F809, 0x08100000.
- mem_ready low 3 cycles during 2nd of 3 writes -> wr_addr/wr_data stable, in_ready 0, no beat lost, done after 3rd write.
- Mnemonic 31 in a len=2 run -> 0x00000000 written, err=1 until next start; len=0 start -> done next cycle, no wr_en; base 0xFF len 2 -> addresses 0xFF then 0x00.
- reset asserted while wr_en held by mem_ready low -> next cycle wr_en 0, busy 0, in_ready 0; fresh run then behaves normally.
